// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one UART TX between two channels; 4-byte frame (HDR, ID, PAY, SUM) then an idle gap.
// req to first byte is 2 cycles; tx_ready low freezes state, tx_data and tx_valid until the byte is accepted.
module tx_frame_scheduler #(
   parameter int          GAP_CYCLES = 16,
   parameter logic [7:0]  HEADER     = 8'h55
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_1,
   input  logic       req_2,
   input  logic [7:0] ch1_data,
   input  logic [7:0] ch2_data,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       grant_1,
   output logic       grant_2,
   output logic       frame_done,
   output logic       busy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_PAY  = 3'd3;
   localparam logic [2:0] S_SUM  = 3'd4;
   localparam logic [2:0] S_GAP  = 3'd5;

   localparam int            CW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [2:0]    state_q, state_d;
   logic          pend_1_q, pend_1_d;
   logic          pend_2_q, pend_2_d;
   logic          last_2_q, last_2_d;
   logic          grant_1_q, grant_1_d;
   logic          grant_2_q, grant_2_d;
   logic [7:0]    pay_q, pay_d;
   logic [7:0]    acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;

   logic accept;
   logic grant_go;
   logic pick_1;
   logic pick_2;

   assign tx_valid   = (state_q == S_HDR) || (state_q == S_ID) ||
                       (state_q == S_PAY) || (state_q == S_SUM);
   assign accept     = tx_valid && tx_ready;
   assign grant_1    = grant_1_q;
   assign grant_2    = grant_2_q;
   assign frame_done = done_q;
   assign busy       = (state_q != S_IDLE);

   // last_2_q set means channel 2 was served last, so channel 1 wins a tie.
   assign pick_1   = pend_1_q && (!pend_2_q || last_2_q);
   assign pick_2   = pend_2_q && !pick_1;
   assign grant_go = (state_q == S_IDLE) && (pend_1_q || pend_2_q);

   always_comb begin
      case (state_q)
         S_HDR:   tx_data = HEADER;
         S_ID:    tx_data = grant_2_q ? 8'h32 : 8'h31;
         S_PAY:   tx_data = pay_q;
         S_SUM:   tx_data = acc_q;
         default: tx_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      last_2_d  = last_2_q;
      grant_1_d = grant_1_q;
      grant_2_d = grant_2_q;
      pay_d     = pay_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      // A request arriving on the granting edge re-arms the latch.
      pend_1_d  = req_1 || (pend_1_q && !(grant_go && pick_1));
      pend_2_d  = req_2 || (pend_2_q && !(grant_go && pick_2));

      case (state_q)
         S_IDLE: begin
            if (grant_go) begin
               state_d   = S_HDR;
               grant_1_d = pick_1;
               grant_2_d = pick_2;
               pay_d     = pick_1 ? ch1_data : ch2_data;
               acc_d     = HEADER;
               last_2_d  = pick_2;
            end
         end
         S_HDR: begin
            if (accept) state_d = S_ID;
         end
         S_ID: begin
            if (accept) begin
               acc_d   = acc_q ^ tx_data;
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            if (accept) begin
               acc_d   = acc_q ^ tx_data;
               state_d = S_SUM;
            end
         end
         S_SUM: begin
            if (accept) begin
               grant_1_d = 1'b0;
               grant_2_d = 1'b0;
               done_d    = 1'b1;
               cnt_d     = '0;
               state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pend_1_q  <= 1'b0;
         pend_2_q  <= 1'b0;
         last_2_q  <= 1'b1;
         grant_1_q <= 1'b0;
         grant_2_q <= 1'b0;
         pay_q     <= 8'h00;
         acc_q     <= 8'h00;
         cnt_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_1_q  <= pend_1_d;
         pend_2_q  <= pend_2_d;
         last_2_q  <= last_2_d;
         grant_1_q <= grant_1_d;
         grant_2_q <= grant_2_d;
         pay_q     <= pay_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: latency, arbitration, gap timing, backpressure and reset abort.
module tb_tx_frame_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_1 = 1'b0;
   logic       req_2 = 1'b0;
   logic [7:0] ch1_data = 8'h00;
   logic [7:0] ch2_data = 8'h00;
   logic       tx_ready = 1'b1;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       grant_1;
   logic       grant_2;
   logic       frame_done;
   logic       busy;

   int tests = 0;
   int fails = 0;

   tx_frame_scheduler #(.GAP_CYCLES(16), .HEADER(8'h55)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_1      (req_1),
      .req_2      (req_2),
      .ch1_data   (ch1_data),
      .ch2_data   (ch2_data),
      .tx_ready   (tx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .grant_1    (grant_1),
      .grant_2    (grant_2),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_hdr(input string tag);
      int n = 0;
      while (tx_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk(tag, {7'd0, tx_valid}, 8'h01);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      chk(tag, {7'd0, busy}, 8'h00);
   endtask

   // Entered on the HDR cycle with tx_ready=1; returns on the frame_done cycle.
   task automatic frame(input string tag, input logic is_ch2, input logic [7:0] pay);
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h55;
      exp_b[1] = is_ch2 ? 8'h32 : 8'h31;
      exp_b[2] = pay;
      exp_b[3] = 8'h55 ^ exp_b[1] ^ pay;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_valid"}, {7'd0, tx_valid}, 8'h01);
         chk({tag, "_byte"},  tx_data, exp_b[i]);
         chk({tag, "_g1"},    {7'd0, grant_1}, {7'd0, !is_ch2});
         chk({tag, "_g2"},    {7'd0, grant_2}, {7'd0, is_ch2});
         tick();
      end
      chk({tag, "_done"},     {7'd0, frame_done}, 8'h01);
      chk({tag, "_gapvalid"}, {7'd0, tx_valid}, 8'h00);
      chk({tag, "_gapgrant"}, {6'd0, grant_1, grant_2}, 8'h00);
      chk({tag, "_gapbusy"},  {7'd0, busy}, 8'h01);
   endtask

   initial begin
      logic [7:0] bp_exp [4];
      int idx;
      int vcnt;

      // Reset state
      tick();
      tick();
      chk("rst_valid", {7'd0, tx_valid}, 8'h00);
      chk("rst_data", tx_data, 8'h00);
      chk("rst_grants", {6'd0, grant_1, grant_2}, 8'h00);
      chk("rst_done", {7'd0, frame_done}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      rst = 1'b0;
      tick();
      chk("idle_valid", {7'd0, tx_valid}, 8'h00);

      // Single channel 1 frame, exact latency, payload change after grant ignored
      req_1 = 1'b1;
      ch1_data = 8'hA5;
      tick();
      req_1 = 1'b0;
      chk("lat_c1_valid", {7'd0, tx_valid}, 8'h00);
      tick();
      ch1_data = 8'hFF;
      frame("f1", 1'b0, 8'hA5);
      tick();
      chk("f1_done_pulse", {7'd0, frame_done}, 8'h00);

      // Simultaneous requests after reset: ch1 first, 17 quiet cycles, then ch2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ch1_data = 8'h5A;
      ch2_data = 8'h00;
      req_1 = 1'b1;
      req_2 = 1'b1;
      tick();
      req_1 = 1'b0;
      req_2 = 1'b0;
      tick();
      frame("arb1", 1'b0, 8'h5A);
      vcnt = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (tx_valid !== 1'b0) vcnt++;
      end
      chk("gap_quiet", vcnt[7:0], 8'h00);
      chk("gap_busy_last", {7'd0, busy}, 8'h00);
      tick();
      frame("arb2", 1'b1, 8'h00);

      // Backpressure: tx_ready toggles 0/1, each byte held until accepted
      wait_idle("bp_idle");
      ch1_data = 8'h3C;
      bp_exp[0] = 8'h55;
      bp_exp[1] = 8'h31;
      bp_exp[2] = 8'h3C;
      bp_exp[3] = 8'h58;
      tx_ready = 1'b0;
      req_1 = 1'b1;
      tick();
      req_1 = 1'b0;
      tick();
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         chk("bp_valid", {7'd0, tx_valid}, 8'h01);
         chk("bp_byte", tx_data, bp_exp[idx]);
         chk("bp_grant", {7'd0, grant_1}, 8'h01);
         tx_ready = (c % 2 == 1);
         tick();
         if (tx_ready) idx++;
      end
      chk("bp_done", {7'd0, frame_done}, 8'h01);
      tx_ready = 1'b1;

      // Three req_2 pulses during a ch1 frame give exactly one ch2 frame
      wait_idle("multi_idle");
      ch1_data = 8'h77;
      ch2_data = 8'h99;
      req_1 = 1'b1;
      tick();
      req_1 = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("multi_c1_valid", {7'd0, tx_valid}, 8'h01);
         chk("multi_c1_g1", {7'd0, grant_1}, 8'h01);
         req_2 = (i % 2 == 0);
         tick();
      end
      chk("multi_c1_done", {7'd0, frame_done}, 8'h01);
      req_2 = 1'b1;
      tick();
      req_2 = 1'b0;
      wait_hdr("multi_c2_start");
      frame("multi_c2", 1'b1, 8'h99);
      vcnt = 0;
      for (int k = 0; k < 45; k++) begin
         tick();
         if (tx_valid !== 1'b0) vcnt++;
      end
      chk("multi_no_extra", vcnt[7:0], 8'h00);

      // Continuous requests alternate grants 1,2,1,2
      ch1_data = 8'h11;
      ch2_data = 8'h22;
      req_1 = 1'b1;
      req_2 = 1'b1;
      wait_hdr("rr_s1");
      frame("rr1", 1'b0, 8'h11);
      wait_hdr("rr_s2");
      frame("rr2", 1'b1, 8'h22);
      wait_hdr("rr_s3");
      frame("rr3", 1'b0, 8'h11);
      wait_hdr("rr_s4");
      frame("rr4", 1'b1, 8'h22);
      req_1 = 1'b0;
      req_2 = 1'b0;

      // Reset during PAY aborts immediately and drops pending requests
      wait_hdr("abort_start");
      chk("abort_hdr", tx_data, 8'h55);
      chk("abort_g1", {7'd0, grant_1}, 8'h01);
      tick();
      tick();
      chk("abort_pay", tx_data, 8'h11);
      rst = 1'b1;
      #1;
      chk("abort_valid", {7'd0, tx_valid}, 8'h00);
      chk("abort_grants", {6'd0, grant_1, grant_2}, 8'h00);
      chk("abort_busy", {7'd0, busy}, 8'h00);
      chk("abort_data", tx_data, 8'h00);
      tick();
      rst = 1'b0;
      vcnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (tx_valid !== 1'b0 || busy !== 1'b0) vcnt++;
      end
      chk("abort_no_frame", vcnt[7:0], 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Shares one UART transmitter between two command channels. Each channel raises a one-cycle request, normally driven by the receive-side command decoder's per-command enable. The scheduler latches the requests and grants them round-robin. For each granted request it sends a fixed 4-byte response frame (header, channel ID, payload, checksum) over a valid/ready byte handshake to the UART TX. It sits between the command decoder and the UART transmitter, and enforces an idle gap between frames.

## Interface
- GAP_CYCLES, 16: idle clock cycles inserted after each frame; 0 means no gap.
- HEADER, 8'h55: first byte of every frame.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_1  input  1  channel 1 request pulse.
- req_2  input  1  channel 2 request pulse.
- ch1_data  input  8  channel 1 payload, sampled at grant.
- ch2_data  input  8  channel 2 payload, sampled at grant.
- tx_ready  input  1  UART TX can accept a byte this cycle.
- tx_valid  output  1  tx_data holds a byte to send.
- tx_data  output  8  byte to transmit.
- grant_1  output  1  high for the whole channel 1 frame, from HDR through SUM.
- grant_2  output  1  high for the whole channel 2 frame, from HDR through SUM.
- frame_done  output  1  one-cycle pulse on the cycle after the checksum is accepted.
- busy  output  1  high in every state except IDLE.

## Operation
- Pending latches pend_1 and pend_2:
  - req_x=1 sets pend_x at the next edge.
  - pend_x clears at the edge that grants channel x.
  - If req_x arrives on the same edge that grants channel x, set wins: pend_x stays 1 and another frame follows.
  - Requests do not count; several pulses while pending give one frame.
- Round-robin: register last_ch resets to 2.
  - Both pending: grant the channel that is not last_ch.
  - One pending: grant it.
  - last_ch updates at each grant.
- States: IDLE, HDR, ID, PAY, SUM, GAP.
- IDLE: when pend_1|pend_2, go to HDR. On that edge:
  - set the granted channel's grant_x;
  - capture the payload register from chx_data;
  - load the checksum accumulator with HEADER.
- HDR: tx_data=HEADER. Advance on tx_valid&&tx_ready.
- ID: tx_data = 8'h31 for channel 1, 8'h32 for channel 2. Advance on handshake. The accumulator XORs in each byte as it is accepted.
- PAY: tx_data = captured payload. Advance on handshake.
- SUM: tx_data = HEADER^ID^payload (8-bit XOR). On handshake:
  - clear grant_x;
  - pulse frame_done;
  - go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: counter runs 0..GAP_CYCLES-1, then IDLE. tx_valid=0. Requests still latch during the gap.
- tx_valid=1 exactly in HDR, ID, PAY, SUM.
- Backpressure: while tx_ready=0, the state, tx_data and tx_valid hold unchanged. Payload changes on chx_data after grant are ignored.
- Counter width is $clog2(GAP_CYCLES+1). The counter saturates and cannot wrap.

## Timing
- Reset values:
  - tx_valid=0, tx_data=8'h00;
  - grant_1=grant_2=0, frame_done=0, busy=0;
  - pend_1=pend_2=0, last_ch=2;
  - state=IDLE, gap counter 0.
- Reset mid-frame aborts immediately. Outputs go to reset values, and pending requests are lost.
- Latency: req_x high in cycle 0 → pend_x in cycle 1 → HDR with tx_valid=1 in cycle 2.
- With tx_ready held at 1, a frame takes 4 cycles, one byte per cycle.
- Frame-to-frame spacing (SUM accept to next HDR): GAP_CYCLES+1 cycles. With GAP_CYCLES=0 this is 1 cycle, through IDLE.
- frame_done and busy are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then req_1 pulse with ch1_data=8'hA5 and tx_ready=1:
  - bytes 55,31,A5,C1 on consecutive cycles starting 2 cycles after req;
  - grant_1 high for those 4 cycles;
  - frame_done 1 cycle later.
- req_1 and req_2 in the same cycle after reset, ch2_data=8'h00: channel 1 frame first, then 16 idle cycles, then 55,32,00,67.
- Backpressure: toggle tx_ready 0/1 each cycle during a frame. Each byte is held stable until accepted, and the frame content is unchanged.
- Three req_2 pulses while a channel 1 frame is in flight: exactly one channel 2 frame follows.
- Continuous requests on both channels: grants alternate 1,2,1,2.
- Assert rst during PAY: tx_valid, grants and busy drop immediately. After release there is no frame until a new request.
